// File: rtl/axis_latency_pipe.sv
// axis_latency_pipe
//   Parametrised, fully handshaked AXI-stream delay pipeline. Every beat is
//   timestamped on entry, and the latency of each tlast beat is measured as it
//   leaves, for RFNoC latency characterisation.
//
//   Build option: define LATPIPE_STATS_EN to add the max_lat / pkt_count
//   statistics. Without it those two outputs are tied to zero.
//
// Parameters
//   WIDTH      tdata width
//   USER_WIDTH tuser width (must be 128 when USER_MODE=1)
//   DEPTH      number of stages, 1..32
//   TS_WIDTH   timestamp / latency arithmetic width, 28..64
//   USER_MODE  0 = tuser pass-through, 1 = {header, 8'h00, timer[27:0], tuser[27:0]}
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   clear           synchronous flush of all stages plus statistics clear
//   i_t*            input AXI-stream (tdata/tuser/tlast/tvalid/tready)
//   o_t*            output AXI-stream (tdata/tuser/tlast/tvalid/tready)
//   timer           free-running vita time
//   header          CHDR header word (USER_MODE=1 only)
//   lat_data        latency of the most recent measured tlast beat
//   lat_valid       one-cycle strobe qualifying lat_data
//   max_lat         largest latency since reset/clear
//   pkt_count       tlast beats delivered since reset/clear
module axis_latency_pipe #(
  parameter int WIDTH      = 32,
  parameter int USER_WIDTH = 128,
  parameter int DEPTH      = 4,
  parameter int TS_WIDTH   = 32,
  parameter int USER_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      i_tdata,
  input  logic [USER_WIDTH-1:0] i_tuser,
  input  logic                  i_tlast,
  input  logic                  i_tvalid,
  output logic                  i_tready,
  output logic [WIDTH-1:0]      o_tdata,
  output logic [USER_WIDTH-1:0] o_tuser,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  input  logic [63:0]           timer,
  input  logic [63:0]           header,
  output logic [TS_WIDTH-1:0]   lat_data,
  output logic                  lat_valid,
  output logic [TS_WIDTH-1:0]   max_lat,
  output logic [31:0]           pkt_count
);

  if (DEPTH < 1 || DEPTH > 32) begin : g_bad_depth
    $error("axis_latency_pipe: DEPTH must be in 1..32");
  end
  if (TS_WIDTH < 28 || TS_WIDTH > 64) begin : g_bad_ts
    $error("axis_latency_pipe: TS_WIDTH must be in 28..64");
  end
  if (USER_MODE != 0 && USER_MODE != 1) begin : g_bad_mode
    $error("axis_latency_pipe: USER_MODE must be 0 or 1");
  end
  if (USER_MODE == 1 && USER_WIDTH != 128) begin : g_bad_user
    $error("axis_latency_pipe: USER_WIDTH must be 128 when USER_MODE=1");
  end

  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0]      adv;
  logic [DEPTH-1:0]      last_q;
  logic [WIDTH-1:0]      data_q [DEPTH];
  logic [USER_WIDTH-1:0] user_q [DEPTH];
  logic [TS_WIDTH-1:0]   ts_q   [DEPTH];
  logic [USER_WIDTH-1:0] user_in;
  logic [TS_WIDTH-1:0]   lat_new;
  logic                  out_meas;

  // Some input bits are intentionally ignored depending on USER_MODE/TS_WIDTH.
  logic unused_inputs;
  assign unused_inputs = ^{header, timer, i_tuser};

  if (USER_MODE == 1) begin : g_user_hdr
    assign user_in = {header, 8'h00, timer[27:0], i_tuser[27:0]};
  end else begin : g_user_pass
    assign user_in = i_tuser;
  end

  // Ready chain: a stage may load if it is empty or its successor moves.
  // Built with a running term so bubbles anywhere downstream open the chain.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = ~vld[DEPTH-1] | o_tready;
    adv[DEPTH-1] = chain;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      chain  = ~vld[k] | chain;
      adv[k] = chain;
    end
  end

  assign i_tready = adv[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= '0;
      last_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        user_q[k] <= '0;
        ts_q[k]   <= '0;
      end
    end else if (clear) begin
      // Payload registers are left as they are; only the valid bits matter.
      vld <= '0;
    end else begin
      if (adv[0]) begin
        vld[0]    <= i_tvalid;
        data_q[0] <= i_tdata;
        last_q[0] <= i_tlast;
        user_q[0] <= user_in;
        ts_q[0]   <= timer[TS_WIDTH-1:0];
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          vld[k]    <= vld[k-1];
          data_q[k] <= data_q[k-1];
          last_q[k] <= last_q[k-1];
          user_q[k] <= user_q[k-1];
          ts_q[k]   <= ts_q[k-1];
        end
      end
    end
  end

  assign o_tvalid = vld[DEPTH-1];
  assign o_tdata  = data_q[DEPTH-1];
  assign o_tuser  = user_q[DEPTH-1];
  assign o_tlast  = last_q[DEPTH-1];

  // Modular subtraction makes timer wrap-around transparent.
  assign out_meas = vld[DEPTH-1] & o_tready & last_q[DEPTH-1];
  assign lat_new  = timer[TS_WIDTH-1:0] - ts_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lat_data  <= '0;
      lat_valid <= 1'b0;
    end else begin
      lat_valid <= out_meas;
      if (out_meas) begin
        lat_data <= lat_new;
      end
    end
  end

`ifdef LATPIPE_STATS_EN
  logic [TS_WIDTH-1:0] max_lat_q;
  logic [31:0]         pkt_count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      max_lat_q   <= '0;
      pkt_count_q <= '0;
    end else if (out_meas) begin
      pkt_count_q <= pkt_count_q + 32'd1;
      if (lat_new > max_lat_q) begin
        max_lat_q <= lat_new;
      end
    end
  end

  assign max_lat   = max_lat_q;
  assign pkt_count = pkt_count_q;
`else
  assign max_lat   = '0;
  assign pkt_count = '0;
`endif

endmodule
